// File: rtl/preprocessor_sequencer.sv
// Sequences accelerometer then magnetometer loads into the angle preprocessor and latches roll/pitch/yaw.
// Optional per-phase wait timeout is compiled in with `define PREPROC_SEQ_TIMEOUT_EN.
module preprocessor_sequencer #(
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sample_req_in,
    input  logic        data_done_in,
    input  logic [15:0] roll_in,
    input  logic [15:0] pitch_in,
    input  logic [15:0] yaw_in,
    output logic        load_acc_out,
    output logic        load_mag_out,
    output logic [15:0] roll_out,
    output logic [15:0] pitch_out,
    output logic [15:0] yaw_out,
    output logic        angles_valid_out,
    output logic        overrun_out,
    output logic        timeout_err_out,
    output logic        busy_out
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ACC,
        WAIT_ACC,
        LOAD_MAG,
        WAIT_MAG,
        DONE
    } state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
        $error("TIMEOUT_CYCLES must lie in 2..255");
    end

    state_t      r_state;
    logic        r_pending;
    logic        r_done_prev;
    logic        r_load_acc;
    logic        r_load_mag;
    logic        r_valid;
    logic        r_overrun;
    logic        r_timeout_err;
    logic        r_busy;
    logic [15:0] r_roll;
    logic [15:0] r_pitch;
    logic [15:0] r_yaw;
    logic        w_done_rise;
    logic        w_timeout;

    // A done level that is already high when a WAIT begins must fall and rise again to count.
    assign w_done_rise = data_done_in & ~r_done_prev;

`ifdef PREPROC_SEQ_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == WAIT_ACC || r_state == WAIT_MAG) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    assign w_timeout = (r_wait_cnt == TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= IDLE;
            r_pending     <= 1'b0;
            r_done_prev   <= 1'b0;
            r_load_acc    <= 1'b0;
            r_load_mag    <= 1'b0;
            r_valid       <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
            r_roll        <= 16'd0;
            r_pitch       <= 16'd0;
            r_yaw         <= 16'd0;
        end else begin
            r_done_prev   <= data_done_in;
            r_load_acc    <= 1'b0;
            r_load_mag    <= 1'b0;
            r_valid       <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;

            // One request may wait behind the running sequence; any further one is dropped.
            if (sample_req_in && r_state != IDLE) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (sample_req_in || r_pending) begin
                        r_state    <= LOAD_ACC;
                        r_load_acc <= 1'b1;
                        r_busy     <= 1'b1;
                        r_pending  <= sample_req_in & r_pending;
                    end
                end
                LOAD_ACC: r_state <= WAIT_ACC;
                WAIT_ACC: begin
                    if (w_done_rise) begin
                        r_roll     <= roll_in;
                        r_pitch    <= pitch_in;
                        r_state    <= LOAD_MAG;
                        r_load_mag <= 1'b1;
                    end else if (w_timeout) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end
                end
                LOAD_MAG: r_state <= WAIT_MAG;
                WAIT_MAG: begin
                    if (w_done_rise) begin
                        r_yaw   <= yaw_in;
                        r_state <= DONE;
                        r_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign load_acc_out     = r_load_acc;
    assign load_mag_out     = r_load_mag;
    assign roll_out         = r_roll;
    assign pitch_out        = r_pitch;
    assign yaw_out          = r_yaw;
    assign angles_valid_out = r_valid;
    assign overrun_out      = r_overrun;
    assign timeout_err_out  = r_timeout_err;
    assign busy_out         = r_busy;

endmodule

// File: tb/tb_preprocessor_sequencer.sv
// Scoreboard bench for preprocessor_sequencer: expected angle triples are queued per request
// and compared when angles_valid_out fires; strobe timing is checked inline.
module tb_preprocessor_sequencer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        sample_req_in = 1'b0;
    logic        data_done_in = 1'b0;
    logic [15:0] roll_in = 16'd0;
    logic [15:0] pitch_in = 16'd0;
    logic [15:0] yaw_in = 16'd0;
    logic        load_acc_out;
    logic        load_mag_out;
    logic [15:0] roll_out;
    logic [15:0] pitch_out;
    logic [15:0] yaw_out;
    logic        angles_valid_out;
    logic        overrun_out;
    logic        timeout_err_out;
    logic        busy_out;

    preprocessor_sequencer #(.TIMEOUT_CYCLES(10)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .sample_req_in    (sample_req_in),
        .data_done_in     (data_done_in),
        .roll_in          (roll_in),
        .pitch_in         (pitch_in),
        .yaw_in           (yaw_in),
        .load_acc_out     (load_acc_out),
        .load_mag_out     (load_mag_out),
        .roll_out         (roll_out),
        .pitch_out        (pitch_out),
        .yaw_out          (yaw_out),
        .angles_valid_out (angles_valid_out),
        .overrun_out      (overrun_out),
        .timeout_err_out  (timeout_err_out),
        .busy_out         (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] p;
        logic [15:0] y;
    } triple_t;

    triple_t exp_q[$];
    triple_t mon_e;
    int      n_cmp = 0;
    int      n_bad = 0;
    int      valid_seen = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every completed sequence.
    always begin
        @(posedge clk);
        #1;
        if (load_acc_out || load_mag_out)
            check_value("strobe_excl", {31'd0, load_acc_out & load_mag_out}, 32'd0);
        if (angles_valid_out) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                check_value("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_value("sb_roll", {16'd0, roll_out}, {16'd0, mon_e.r});
                check_value("sb_pitch", {16'd0, pitch_out}, {16'd0, mon_e.p});
                check_value("sb_yaw", {16'd0, yaw_out}, {16'd0, mon_e.y});
                $display("txn %0d: roll=%04h pitch=%04h yaw=%04h", valid_seen, roll_out, pitch_out, yaw_out);
            end
        end
    end

    // One full sequence. Cycle 0 carries the request (or, with pend, is the IDLE cycle that
    // consumes a pending request); done rises at acc_at and mag_at; ends in the DONE cycle.
    task automatic run_seq(input logic [15:0] r, input logic [15:0] p, input logic [15:0] y,
                           input int acc_at, input int mag_at, input bit stale, input bit pend,
                           input int x1, input int x2);
        int cyc;
        exp_q.push_back({r, p, y});
        if (stale) begin
            data_done_in = 1'b1;
            roll_in      = ~r;
            pitch_in     = ~p;
        end
        if (pend) begin
            step();
            sample_req_in = 1'b0;
            check_value("pend_idle_busy", {31'd0, busy_out}, 32'd0);
            check_value("pend_idle_load", {31'd0, load_acc_out}, 32'd0);
        end else begin
            sample_req_in = 1'b1;
        end
        step();
        sample_req_in = 1'b0;
        cyc = 1;
        check_value("load_acc", {31'd0, load_acc_out}, 32'd1);
        check_value("busy", {31'd0, busy_out}, 32'd1);
        while (cyc < acc_at) begin
            data_done_in  = stale && (cyc < acc_at - 1);
            sample_req_in = (cyc == x1) || (cyc == x2);
            step();
            cyc++;
            check_value("no_early_mag", {31'd0, load_mag_out}, 32'd0);
            if (x2 >= 0)
                check_value("overrun", {31'd0, overrun_out}, {31'd0, cyc == x2 + 1});
        end
        sample_req_in = 1'b0;
        roll_in       = r;
        pitch_in      = p;
        data_done_in  = 1'b1;
        step();
        cyc++;
        data_done_in = 1'b0;
        roll_in      = 16'($urandom);
        pitch_in     = 16'($urandom);
        check_value("load_mag", {31'd0, load_mag_out}, 32'd1);
        while (cyc < mag_at) begin
            step();
            cyc++;
            check_value("no_early_valid", {31'd0, angles_valid_out}, 32'd0);
        end
        yaw_in       = y;
        data_done_in = 1'b1;
        step();
        data_done_in = 1'b0;
        yaw_in       = 16'($urandom);
        check_value("valid", {31'd0, angles_valid_out}, 32'd1);
    endtask

    initial begin
        int v0;
        bit seen_bad;
        logic [15:0] yaw_before;

        // Reset state
        step();
        step();
        check_value("rst_busy", {31'd0, busy_out}, 32'd0);
        check_value("rst_loads", {30'd0, load_acc_out, load_mag_out}, 32'd0);
        check_value("rst_status", {29'd0, angles_valid_out, overrun_out, timeout_err_out}, 32'd0);
        check_value("rst_angles", {roll_out, pitch_out | yaw_out}, 32'd0);
        n_rst = 1'b1;
        step();

        // Nominal timeline, then stale done level, then back-to-back distinct data
        run_seq(16'h0123, 16'hFF10, 16'h0B40, 5, 12, 1'b0, 1'b0, -1, -1);
        step();
        run_seq(16'hA5A5, 16'h5A5A, 16'h7FFF, 5, 12, 1'b1, 1'b0, -1, -1);
        step();

        // Backpressure: second request overruns, exactly one follow-on
        run_seq(16'h1001, 16'h2002, 16'h3003, 5, 12, 1'b0, 1'b0, 2, 3);
        run_seq(16'h8000, 16'h0001, 16'hFFFF, 4, 9, 1'b0, 1'b1, -1, -1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("no_second_followon", {31'd0, busy_out}, 32'd0);
        end

        // Request coinciding with DONE is held and started from the following IDLE cycle
        run_seq(16'h0F0F, 16'hF0F0, 16'h1234, 3, 6, 1'b0, 1'b0, -1, -1);
        sample_req_in = 1'b1;
        run_seq(16'h4321, 16'h8765, 16'hCAFE, 5, 8, 1'b0, 1'b1, -1, -1);
        step();

`ifdef PREPROC_SEQ_TIMEOUT_EN
        // Magnetometer never completes: timeout 10 cycles into WAIT_MAG, yaw untouched
        yaw_before    = yaw_out;
        sample_req_in = 1'b1;
        step();
        sample_req_in = 1'b0;
        for (int c = 1; c < 5; c++) step();
        roll_in      = 16'h1111;
        pitch_in     = 16'h2222;
        data_done_in = 1'b1;
        step();
        data_done_in = 1'b0;
        check_value("to_load_mag", {31'd0, load_mag_out}, 32'd1);
        for (int c = 7; c <= 17; c++) begin
            step();
            check_value("timeout_pulse", {31'd0, timeout_err_out}, {31'd0, c == 17});
        end
        step();
        check_value("to_busy_low", {31'd0, busy_out}, 32'd0);
        check_value("to_yaw_held", {16'd0, yaw_out}, {16'd0, yaw_before});
        check_value("to_roll_latched", {16'd0, roll_out}, 32'h1111);

        sample_req_in = 1'b1;
        step();
        sample_req_in = 1'b0;
        step();
        step();
`else
        // No timeout logic: a missing done leaves the block waiting forever
        seen_bad      = 1'b0;
        sample_req_in = 1'b1;
        step();
        sample_req_in = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (timeout_err_out || load_mag_out || !busy_out) seen_bad = 1'b1;
        end
        check_value("wait_forever", {31'd0, seen_bad}, 32'd0);
        check_value("wait_timeout_low", {31'd0, timeout_err_out}, 32'd0);
`endif

        // Reset in WAIT_ACC: outputs clear at once, no completion, fresh request works
        v0 = valid_seen;
        #2;
        n_rst = 1'b0;
        #1;
        check_value("mid_rst_busy", {31'd0, busy_out}, 32'd0);
        check_value("mid_rst_angles", {roll_out, pitch_out | yaw_out}, 32'd0);
        data_done_in = 1'b1;
        for (int c = 0; c < 3; c++) step();
        data_done_in = 1'b0;
        check_value("mid_rst_no_valid", valid_seen, v0);
        check_value("mid_rst_status", {29'd0, angles_valid_out, overrun_out, timeout_err_out}, 32'd0);
        n_rst = 1'b1;
        run_seq(16'h0ACE, 16'hBEEF, 16'h0042, 5, 12, 1'b0, 1'b0, -1, -1);
        step();
        step();

        check_value("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/preprocessor_sequencer.md
PREPROCESSOR_SEQUENCER -- requirements
Module: preprocessor_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 200, the maximum cycles waited for data_done_in per phase (range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port sample_req_in, input, 1, a one-cycle pulse meaning a new raw sensor sample is available in the register map.
REQ-005 The block SHALL have port data_done_in, input, 1, the preprocessor done flag (level).
REQ-006 The block SHALL have ports roll_in, pitch_in, yaw_in, input, 16 each, the preprocessor angle results.
REQ-007 The block SHALL have ports load_acc_out and load_mag_out, output, 1 each, one-cycle load strobes to the preprocessor.
REQ-008 The block SHALL have ports roll_out, pitch_out, yaw_out, output, 16 each, the latched angle triple.
REQ-009 The block SHALL have ports angles_valid_out, overrun_out and timeout_err_out, output, 1 each, one-cycle status pulses.
REQ-010 The block SHALL have port busy_out, output, 1, high in every state except IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD_ACC, WAIT_ACC, LOAD_MAG, WAIT_MAG and DONE.
REQ-012 In IDLE, sample_req_in high or pending set SHALL move to LOAD_ACC and clear pending.
REQ-013 LOAD_ACC SHALL last one cycle with load_acc_out high, then go to WAIT_ACC; LOAD_MAG likewise asserts load_mag_out and goes to WAIT_MAG.
REQ-014 Completion in WAIT_x SHALL be a rising edge of data_done_in (registered previous value 0, current value 1); a level already high on WAIT entry is ignored until it falls and rises again.
REQ-015 On WAIT_ACC completion, roll_in and pitch_in SHALL be latched into roll_out and pitch_out, and the FSM goes to LOAD_MAG.
REQ-016 On WAIT_MAG completion, yaw_in SHALL be latched into yaw_out, and the FSM goes to DONE.
REQ-017 DONE SHALL last one cycle with angles_valid_out high, then return to IDLE.
REQ-018 Latency from the sample_req_in pulse to load_acc_out SHALL be exactly one cycle.
REQ-019 sample_req_in while busy_out is high SHALL set a one-deep pending flag.
REQ-020 sample_req_in while pending is already set SHALL pulse overrun_out in the next cycle and drop that request.
REQ-021 sample_req_in in the same cycle DONE returns to IDLE SHALL set pending; IDLE then starts the next sequence the cycle after.
REQ-022 Outputs roll_out, pitch_out and yaw_out SHALL hold their values between updates; a partial sequence (acc latched, mag not) leaves yaw_out at its old value.
REQ-023 load_acc_out and load_mag_out SHALL never be high in the same cycle.

Reset
REQ-024 While n_rst is low, the FSM SHALL be in IDLE with all outputs 0, pending 0, the edge register 0 and the timeout counter 0, independent of clk.
REQ-025 Reset asserted mid-sequence SHALL abandon the sequence with no angles_valid_out pulse.
REQ-026 After reset is released, the first rising clk edge with sample_req_in high SHALL start a new sequence.

Configuration
REQ-027 With macro PREPROC_SEQ_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to each WAIT state and increment each WAIT cycle.
REQ-028 With PREPROC_SEQ_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES without completion SHALL pulse timeout_err_out, return the FSM to IDLE, leave pending unchanged and produce no angles_valid_out.
REQ-029 Without PREPROC_SEQ_TIMEOUT_EN, the counter SHALL be absent, timeout_err_out SHALL be tied to 0, and WAIT states SHALL wait indefinitely.

Verification
REQ-030 Nominal: sample_req_in pulse at cycle 0, data_done_in rising at cycle 5 with roll=0x0123 and pitch=0xFF10, rising again at cycle 12 with yaw=0x0B40 -> load_acc_out at cycle 1, load_mag_out at cycle 6, angles_valid_out at cycle 13 with outputs 0x0123/0xFF10/0x0B40.
REQ-031 Stale done: data_done_in held high across the load_acc_out strobe and then falling/rising 4 cycles later -> completion only on that later edge.
REQ-032 Backpressure: two requests during one busy sequence -> the second pulses overrun_out; exactly one follow-on sequence starts one cycle after DONE.
REQ-033 Timeout (macro defined, TIMEOUT_CYCLES=10): no done after load_mag_out -> timeout_err_out 10 cycles after WAIT_MAG entry, busy_out low next, yaw_out unchanged.
REQ-034 Reset mid-WAIT_ACC: n_rst low for 3 cycles -> all outputs 0 immediately and no angles_valid_out; a fresh request afterwards completes normally.
REQ-035 Macro undefined: no done for 1000 cycles -> FSM remains in WAIT_ACC and timeout_err_out stays 0.
